control_sequencer: RTL and testbench

//  Drives the instruction decoders: fetches a 32-bit instruction, holds it in an instruction register (I).

---
 rtl/cpu_ctrl_pkg.sv | 37 +++
 rtl/control_sequencer_if.sv | 18 +
 rtl/control_sequencer_cw_gate.sv | 22 ++
 rtl/control_sequencer.sv | 108 ++++++++++
 tb/tb_control_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared control-word layout, phase encoding and constants
package cpu_ctrl_pkg;

  localparam int CW_WIDTH = 33;

  localparam int CW_ALU_ENABLE  = 32;
  localparam int CW_ALU_BS      = 31;
  localparam int CW_ALU_FS_HI   = 30;
  localparam int CW_ALU_FS_LO   = 26;
  localparam int CW_RF_B_EN     = 25;
  localparam int CW_SA_HI       = 24;
  localparam int CW_SA_LO       = 20;
  localparam int CW_SB_HI       = 19;
  localparam int CW_SB_LO       = 15;
  localparam int CW_WA_HI       = 14;
  localparam int CW_WA_LO       = 10;
  localparam int CW_REG_W       = 9;
  localparam int CW_RAM_EN      = 8;
  localparam int CW_RAM_W       = 7;
  localparam int CW_PC_EN       = 6;
  localparam int CW_PC_FS_HI    = 5;
  localparam int CW_PC_FS_LO    = 4;
  localparam int CW_PC_SEL      = 3;
  localparam int CW_STATUS_LOAD = 2;
  localparam int CW_NS_HI       = 1;
  localparam int CW_NS_LO       = 0;

  localparam logic [CW_WIDTH-1:0] CW_NOP    = '0;
  localparam logic [1:0]          PC_FS_INC = 2'b01;

  typedef enum logic [1:0] {
    PH_FETCH   = 2'd0,
    PH_EXECUTE = 2'd1,
    PH_HALT    = 2'd2
  } phase_e;

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction fetch handshake between sequencer and RAM
interface control_sequencer_if;
  logic [31:0] mem_data;
  logic        mem_valid;
  logic        fetch_req;

  modport master (
    input  mem_data,
    input  mem_valid,
    output fetch_req
  );

  modport slave (
    output mem_data,
    output mem_valid,
    input  fetch_req
  );
endinterface

// File: rtl/control_sequencer_cw_gate.sv
// rtl/control_sequencer_cw_gate.sv - selects decoder word, PC-increment word or NOP onto the datapath
module control_sequencer_cw_gate
  import cpu_ctrl_pkg::*;
#(
  parameter int CW_W = CW_WIDTH
) (
  input  logic            exec_en_i,
  input  logic            fetch_inc_i,
  input  logic [CW_W-1:0] cw_in_i,
  output logic [CW_W-1:0] cw_out_o
);

  always_comb begin
    cw_out_o = CW_NOP;
    if (exec_en_i) begin
      cw_out_o = cw_in_i;
    end else if (fetch_inc_i) begin
      cw_out_o[CW_PC_FS_HI:CW_PC_FS_LO] = PC_FS_INC;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute/halt sequencer owning IR, step, status and retired count
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CW_W  = CW_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  control_sequencer_if.master mem_bus,
  output logic [31:0]         I,
  output logic [1:0]          state,
  output logic [4:0]          status,
  input  logic [CW_W-1:0]     cw_in,
  input  logic [4:0]          alu_status,
  output logic [CW_W-1:0]     cw_out,
  input  logic                halt_req,
  input  logic                resume,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  phase_e             phase_q, phase_d;
  logic [31:0]        ir_q, ir_d;
  logic [1:0]         state_q, state_d;
  logic [4:0]         status_q, status_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic               in_fetch;
  logic               in_exec;
  logic               handshake;
  logic [1:0]         ns;

  // Reset forces FETCH asynchronously, so fetch outputs also need reset_n gating.
  assign in_fetch  = reset_n && (phase_q == PH_FETCH);
  assign in_exec   = reset_n && (phase_q == PH_EXECUTE);
  assign handshake = in_fetch && mem_bus.mem_valid;
  assign ns        = cw_in[CW_NS_HI:CW_NS_LO];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= PH_FETCH;
      ir_q      <= '0;
      state_q   <= '0;
      status_q  <= '0;
      retired_q <= '0;
    end else begin
      phase_q   <= phase_d;
      ir_q      <= ir_d;
      state_q   <= state_d;
      status_q  <= status_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    ir_d      = ir_q;
    state_d   = state_q;
    status_d  = status_q;
    retired_d = retired_q;
    case (phase_q)
      PH_FETCH: begin
        if (mem_bus.mem_valid) begin
          ir_d    = mem_bus.mem_data;
          state_d = '0;
          phase_d = PH_EXECUTE;
        end
      end
      PH_EXECUTE: begin
        if (cw_in[CW_STATUS_LOAD]) begin
          status_d = alu_status;
        end
        if (ns != 2'b00) begin
          state_d = ns;
        end else begin
          // Completion cycle is the only point where a halt request is honoured.
          retired_d = retired_q + 1'b1;
          state_d   = '0;
          phase_d   = halt_req ? PH_HALT : PH_FETCH;
        end
      end
      PH_HALT: begin
        if (resume) begin
          phase_d = PH_FETCH;
        end
      end
      default: phase_d = PH_FETCH;
    endcase
  end

  control_sequencer_cw_gate #(
    .CW_W (CW_W)
  ) u_cw_gate (
    .exec_en_i   (in_exec),
    .fetch_inc_i (handshake),
    .cw_in_i     (cw_in),
    .cw_out_o    (cw_out)
  );

  assign mem_bus.fetch_req = in_fetch;
  assign I                 = ir_q;
  assign state             = state_q;
  assign status            = status_q;
  assign halted            = (phase_q == PH_HALT);
  assign retired           = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clock;
  logic        reset_n;
  logic [32:0] cw_in;
  logic [4:0]  alu_status;
  logic        halt_req;
  logic        resume;
  logic [31:0] I;
  logic [1:0]  state;
  logic [4:0]  status;
  logic [32:0] cw_out;
  logic        halted;
  logic [15:0] retired;

  int checks;
  int failures;

  control_sequencer_if mem_bus ();

  control_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mem_bus    (mem_bus),
    .I          (I),
    .state      (state),
    .status     (status),
    .cw_in      (cw_in),
    .alu_status (alu_status),
    .cw_out     (cw_out),
    .halt_req   (halt_req),
    .resume     (resume),
    .halted     (halted),
    .retired    (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    mem_bus.mem_data = 32'h91000421;
    mem_bus.mem_valid = 1'b1;
    cw_in = 33'h1_2345_6780;
    alu_status = 5'b0;
    halt_req = 1'b0;
    resume = 1'b0;
    #12;
    check("rst_fetch_req", {63'd0, mem_bus.fetch_req}, 64'd0);
    check("rst_cw_out", {31'd0, cw_out}, 64'd0);
    check("rst_I", {32'd0, I}, 64'd0);
    check("rst_state", {62'd0, state}, 64'd0);
    check("rst_status", {59'd0, status}, 64'd0);
    check("rst_retired", {48'd0, retired}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);

    // Test 1: single-step instruction
    reset_n = 1'b1;
    #1;
    check("t1_fetch_req", {63'd0, mem_bus.fetch_req}, 64'd1);
    check("t1_cw_pc_inc", {31'd0, cw_out}, 64'h10);
    tick();
    mem_bus.mem_valid = 1'b0;
    #1;
    check("t1_I", {32'd0, I}, 64'h91000421);
    check("t1_exec_fetch_req", {63'd0, mem_bus.fetch_req}, 64'd0);
    check("t1_cw_pass", {31'd0, cw_out}, 64'h1_2345_6780);
    tick();
    check("t1_retired", {48'd0, retired}, 64'd1);
    check("t1_fetch_again", {63'd0, mem_bus.fetch_req}, 64'd1);
    check("t1_status_kept", {59'd0, status}, 64'd0);

    // Tests 2 and 3: three-step instruction with status load
    mem_bus.mem_data = 32'hA5A5_0001;
    mem_bus.mem_valid = 1'b1;
    tick();
    mem_bus.mem_valid = 1'b0;
    cw_in = 33'h0_0000_0205;
    alu_status = 5'b10101;
    resume = 1'b1;
    #1;
    check("t2_state0", {62'd0, state}, 64'd0);
    check("t2_I", {32'd0, I}, 64'hA5A5_0001);
    tick();
    resume = 1'b0;
    cw_in = 33'h0_0000_0042;
    alu_status = 5'b01010;
    #1;
    check("t2_state1", {62'd0, state}, 64'd1);
    check("t3_status_load", {59'd0, status}, 64'h15);
    check("t2_retired_mid", {48'd0, retired}, 64'd1);
    check("t2_not_halted", {63'd0, halted}, 64'd0);
    tick();
    cw_in = 33'h1_0000_0000;
    #1;
    check("t2_state2", {62'd0, state}, 64'd2);
    check("t3_status_hold", {59'd0, status}, 64'h15);
    check("t2_retired_mid2", {48'd0, retired}, 64'd1);
    tick();
    check("t2_state_done", {62'd0, state}, 64'd0);
    check("t2_retired", {48'd0, retired}, 64'd2);
    check("t2_fetch_req", {63'd0, mem_bus.fetch_req}, 64'd1);

    // Test 4: halt request during a three-step instruction
    mem_bus.mem_data = 32'h0000_BEEF;
    mem_bus.mem_valid = 1'b1;
    tick();
    mem_bus.mem_valid = 1'b0;
    cw_in = 33'h0_0000_0001;
    tick();
    cw_in = 33'h0_0000_0002;
    halt_req = 1'b1;
    tick();
    check("t4_no_abort", {63'd0, halted}, 64'd0);
    check("t4_state2", {62'd0, state}, 64'd2);
    cw_in = 33'h1_FFFF_FFF8;
    tick();
    halt_req = 1'b0;
    #1;
    check("t4_halted", {63'd0, halted}, 64'd1);
    check("t4_fetch_req", {63'd0, mem_bus.fetch_req}, 64'd0);
    check("t4_cw_nop", {31'd0, cw_out}, 64'd0);
    check("t4_retired", {48'd0, retired}, 64'd3);
    mem_bus.mem_valid = 1'b1;
    tick();
    check("t4_still_halted", {63'd0, halted}, 64'd1);
    check("t4_I_kept", {32'd0, I}, 64'h0000_BEEF);
    mem_bus.mem_valid = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    check("t4_resume_halted", {63'd0, halted}, 64'd0);
    check("t4_resume_fetch", {63'd0, mem_bus.fetch_req}, 64'd1);

    // Test 5: asynchronous reset in the middle of EXECUTE
    mem_bus.mem_data = 32'h1234_5678;
    mem_bus.mem_valid = 1'b1;
    tick();
    mem_bus.mem_valid = 1'b0;
    cw_in = 33'h1_0000_0005;
    alu_status = 5'b11111;
    tick();
    #2;
    check("t5_pre_state", {62'd0, state}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("t5_I", {32'd0, I}, 64'd0);
    check("t5_state", {62'd0, state}, 64'd0);
    check("t5_status", {59'd0, status}, 64'd0);
    check("t5_retired", {48'd0, retired}, 64'd0);
    check("t5_cw_out", {31'd0, cw_out}, 64'd0);
    check("t5_fetch_req", {63'd0, mem_bus.fetch_req}, 64'd0);
    check("t5_halted", {63'd0, halted}, 64'd0);
    tick();
    reset_n = 1'b1;
    cw_in = 33'h0;

    // Test 6: retired counter wraps
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    tick();
    check("t6_preload", {48'd0, retired}, 64'hFFFF);
    mem_bus.mem_valid = 1'b1;
    tick();
    mem_bus.mem_valid = 1'b0;
    tick();
    check("t6_wrap", {48'd0, retired}, 64'd0);
    check("t6_fetch_req", {63'd0, mem_bus.fetch_req}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
